// File: rtl/fetch_queue_pkg.sv
// ============================================================================
// fetch_queue_pkg : shared types and widths for the instruction fetch stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_queue_pkg;

    localparam int c_addr_w = 32;
    localparam int c_word_w = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [c_addr_w-1:0] pc;
        logic [c_word_w-1:0] instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : circular buffer of {pc, instr} entries with push/pop/flush
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [c_addr_w-1:0]   wr_pc,
    input  logic [c_word_w-1:0]   wr_instr,
    output logic [c_addr_w-1:0]   rd_pc,
    output logic [c_word_w-1:0]   rd_instr,
    output logic [$clog2(DEPTH):0] count,
    output logic                  full,
    output logic                  empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_full_cnt = (c_ptr_w + 1)'(DEPTH);

    fetch_entry_t       r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_full_cnt);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign rd_pc     = r_mem[r_rd_ptr].pc;
    assign rd_instr  = r_mem[r_rd_ptr].instr;

    // Pointers are log2(DEPTH) wide so they wrap naturally; flush leaves storage intact.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= '{pc: wr_pc, instr: wr_instr};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : single-outstanding instruction fetcher feeding a small queue
// Optional FETCH_PERF_EN adds perf_fetched / perf_dropped counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                 DEPTH    = 4,
    parameter logic [c_addr_w-1:0] RESET_PC = 32'h0
)
(
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [c_addr_w-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [c_word_w-1:0] imem_rdata,
    output logic                ir_valid,
    input  logic                ir_ready,
    output logic [c_word_w-1:0] ir_data,
    output logic [c_addr_w-1:0] ir_pc,
    input  logic                redirect,
    input  logic [c_addr_w-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]         perf_fetched,
    output logic [15:0]         perf_dropped
`endif
);

    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    fetch_state_t        r_state;
    fetch_state_t        w_next_state;
    logic                r_req;
    logic [c_addr_w-1:0] r_addr;
    logic [c_addr_w-1:0] r_fetch_pc;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic [c_cnt_w-1:0]  w_count;
    logic                w_full;
    logic                w_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (!redirect && !w_full) w_next_state = ST_REQ;
            ST_REQ: begin
                if (imem_ack)      w_next_state = ST_IDLE;
                else if (redirect) w_next_state = ST_DROP;
            end
            ST_DROP: if (imem_ack) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_issue = 1'b0;
        w_push  = 1'b0;
        case (r_state)
            ST_IDLE: w_issue = ~redirect & ~w_full;
            ST_REQ:  w_push  = imem_ack & ~redirect;
            default: ;
        endcase
    end

    // Request and address are registered; the address is captured at issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_req <= (w_next_state != ST_IDLE);
            if (w_issue) begin
                r_addr <= r_fetch_pc;
            end
            if (redirect) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd1;
            end
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign w_pop     = ~w_empty & ir_ready;
    assign ir_valid  = ~w_empty;

    fetch_fifo #(
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push),
        .pop      (w_pop),
        .flush    (redirect),
        .wr_pc    (r_fetch_pc),
        .wr_instr (imem_rdata),
        .rd_pc    (ir_pc),
        .rd_instr (ir_data),
        .count    (w_count),
        .full     (w_full),
        .empty    (w_empty)
    );

`ifdef FETCH_PERF_EN
    logic               w_discard;
    logic [c_cnt_w-1:0] w_flushed;
    logic [16:0]        w_drop_sum;
    logic [15:0]        r_perf_fetched;
    logic [15:0]        r_perf_dropped;

    // An entry popped in the redirect cycle was consumed, not dropped.
    assign w_discard  = imem_ack & (((r_state == ST_REQ) & redirect) | (r_state == ST_DROP));
    assign w_flushed  = redirect ? (w_count - c_cnt_w'(w_pop)) : '0;
    assign w_drop_sum = {1'b0, r_perf_dropped} + 17'(w_flushed) + 17'(w_discard);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_fetched <= '0;
            r_perf_dropped <= '0;
        end else begin
            if (w_push && r_perf_fetched != 16'hFFFF) begin
                r_perf_fetched <= r_perf_fetched + 16'd1;
            end
            r_perf_dropped <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_dropped = r_perf_dropped;
`endif

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage that sits directly upstream of the multicycle processor core. It generates word addresses, issues single-outstanding requests to instruction memory, and buffers returned instruction words with their PCs in a small FIFO. The core consumes them over a valid/ready handshake. Branch, jump, call and return targets arrive on a redirect port, which flushes the queue and discards any in-flight response.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 32'h0: fetch address after reset.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 resets the block.
- imem_req  out  1  request valid; held until imem_ack.
- imem_addr  out  32  word address of the request; stable while imem_req=1.
- imem_ack  in  1  response strobe; may arrive in the request cycle or any later cycle.
- imem_rdata  in  32  instruction word; valid only when imem_ack=1.
- ir_valid  out  1  queue head is valid.
- ir_ready  in  1  core accepts the head.
- ir_data  out  32  head instruction word.
- ir_pc  out  32  head instruction address.
- redirect  in  1  one-cycle strobe that flushes the queue and restarts fetch.
- redirect_pc  in  32  new fetch address; sampled when redirect=1.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - REQ: request outstanding, response kept.
  - DROP: request outstanding, response discarded.
- IDLE→REQ when no redirect and count < DEPTH. The request carries fetch_pc.
- REQ, imem_ack=1, no redirect: push {fetch_pc, imem_rdata}, set fetch_pc += 1 (mod 2^32), go to IDLE.
- REQ, redirect=1 with no ack: go to DROP.
- REQ, redirect=1 with ack in the same cycle: discard the data and go to IDLE.
- DROP, ack: discard the data and go to IDLE. A redirect while in DROP only updates fetch_pc.
- Every redirect sets fetch_pc ← redirect_pc and count ← 0, whatever the state.
- Pop on ir_valid & ir_ready. Push and pop in the same cycle leave count unchanged.
- Redirect with a simultaneous pop: the pop counts as consumed by the core, and the queue is still emptied.
- A full queue issues no request. An empty queue holds ir_valid=0.
- Read and write pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Reset values: imem_req=0, imem_addr=RESET_PC, ir_valid=0, ir_data=0, ir_pc=0, fetch_pc=RESET_PC, count=0, state=IDLE.
- Reset asserted mid-request drops the outstanding transaction. Memory must tolerate an abandoned request.

## Timing
- imem_req is registered. It rises one cycle after the IDLE→REQ decision.
- Minimum fetch-to-issue latency: ack in the request cycle → ir_valid=1 on the next cycle. There is no bypass.
- Peak throughput is one instruction per two cycles (IDLE/REQ alternation), which exceeds core demand.
- After a redirect, the first word from redirect_pc appears at ir_valid no earlier than 2 cycles after the redirect cycle. The delay grows by the residual latency of any dropped response.
- ir_data and ir_pc are driven from queue storage and stay stable while ir_valid=1 and ir_ready=0.

## Configuration
- FETCH_PERF_EN defined: adds two outputs and two 16-bit saturating counters.
  - perf_fetched (out, 16): counts pushes.
  - perf_dropped (out, 16): counts responses discarded in REQ/DROP plus valid entries flushed by redirect.
  - Both counters reset to 0.
- FETCH_PERF_EN undefined: neither port nor counter exists, and behaviour is otherwise identical.

## Structure
- Shared package holds:
  - the state enum (IDLE, REQ, DROP);
  - the 32-bit address/word width constants;
  - the {pc, instr} entry struct.
- Sub-module fetch_fifo: parameterised DEPTH circular buffer with push, pop, flush, count, full and empty. The FSM and address generation stay in fetch_queue.

## Test plan
- Reset, RESET_PC=0, 1-cycle-latency memory returning instr = addr^32'hA5A5_0000, ir_ready=1 → ir_pc sequence 0,1,2,3 with matching ir_data, no gaps beyond the 2-cycle cadence.
- ir_ready=0 for 20 cycles → count reaches 4, imem_req stays 0 once full. Release → entries pcs 0..3 drain in order, then fetch resumes at 4.
- Memory with 5-cycle latency, redirect_pc=32'h40 pulsed 2 cycles after the request → that ack is discarded (state DROP), next request addr=32'h40, ir_pc=32'h40 is the first visible entry.
- Redirect in the same cycle as ack and as a pop with 3 entries queued → the acked word is not pushed, count=0 next cycle, next imem_addr=redirect_pc.
- reset driven low mid-REQ, then released → imem_req=0 and ir_valid=0 during reset, first post-reset request addr=RESET_PC.
- With FETCH_PERF_EN: 10 fetched, then a redirect flushing 3 entries plus 1 in-flight → perf_fetched=10, perf_dropped=4.
